// File: rtl/inv_chk_pkg.sv
// Shared types and constants for the inverter gate checker.
// Optional feature macro: INV_CHK_LFSR_EN (pseudo-random stimulus pattern).
package inv_chk_pkg;

    localparam int unsigned ERR_W     = 8;
    localparam logic [3:0]  LFSR_SEED = 4'b0001;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    // Fibonacci LFSR step for x^4 + x^3 + 1, shifting toward the MSB.
    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/inv_gate_checker.sv
// Drives a test pattern into an external inverter, samples its output after
// a settle window and counts mismatches against the expected inverted value.
// Optional feature macro: INV_CHK_LFSR_EN selects an LFSR pattern instead of
// the alternating 0,1,0,1 pattern.
module inv_gate_checker
    import inv_chk_pkg::*;
#(
    parameter int unsigned NUM_VECTORS   = 16,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             stim,
    input  logic             resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       vec_idx
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [7:0]  LAST_IDX = 8'(NUM_VECTORS - 1);

    if (SETTLE_CYCLES < 2) begin : g_bad_settle
        $error("inv_gate_checker: SETTLE_CYCLES must be >= 2 to cover synchronizer latency");
    end
    if (NUM_VECTORS < 2 || NUM_VECTORS > 255) begin : g_bad_vectors
        $error("inv_gate_checker: NUM_VECTORS must be in 2..255");
    end

    state_e           state_q;
    logic             stim_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic [7:0]       vec_q;
    logic [CNT_W-1:0] cnt_q;
    logic             resp_sync;
    logic             pat_bit;
    logic             mismatch;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (resp),
        .q_o   (resp_sync)
    );

`ifdef INV_CHK_LFSR_EN
    logic [3:0] lfsr_q;

    // Pattern source: reload on run start, step once per applied vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (state_q == IDLE && start) begin
            lfsr_q <= LFSR_SEED;
        end else if (state_q == DRIVE) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign pat_bit = lfsr_q[0];
`else
    assign pat_bit = vec_q[0];
`endif

    // A healthy inverter returns the complement of what was driven.
    assign mismatch = (resp_sync == stim_q);

    // Run sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stim_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= DRIVE;
                        busy_q  <= 1'b1;
                        vec_q   <= '0;
                        err_q   <= '0;
                        pass_q  <= 1'b0;
                    end
                end
                DRIVE: begin
                    stim_q  <= pat_bit;
                    cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (mismatch && err_q != '1) begin
                        err_q <= err_q + 1'b1;
                    end
                    if (vec_q == LAST_IDX) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        vec_q   <= vec_q + 8'd1;
                        state_q <= DRIVE;
                    end
                end
                DONE: begin
                    pass_q  <= (err_q == '0);
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stim      = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign vec_idx   = vec_q;

endmodule

// File: tb/tb_inv_gate_checker.sv
// Directed bench for inv_gate_checker: table of full runs plus hand-written
// reset, restart and saturation sequences.
module tb_inv_gate_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       resp;
    logic       stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] vec_idx;
    logic [1:0] mode;   // 0 ideal inverter, 1 stuck at 0, 2 buffer

    logic       start_b;
    logic       resp_b;
    logic       stim_b;
    logic       busy_b;
    logic       done_b;
    logic       pass_b;
    logic [7:0] err_b;
    logic [7:0] vec_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] pat;
    int          zeros16;

    always #5 clk = ~clk;

    assign #1 resp   = (mode == 2'd0) ? ~stim : (mode == 2'd1) ? 1'b0 : stim;
    assign #1 resp_b = stim_b;

    inv_gate_checker #(.NUM_VECTORS(16), .SETTLE_CYCLES(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stim      (stim),
        .resp      (resp),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .vec_idx   (vec_idx)
    );

    inv_gate_checker #(.NUM_VECTORS(255), .SETTLE_CYCLES(2)) u_big (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .stim      (stim_b),
        .resp      (resp_b),
        .busy      (busy_b),
        .done      (done_b),
        .pass      (pass_b),
        .err_count (err_b),
        .vec_idx   (vec_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        logic [1:0] mode;
        int         start_at;  // cycle at which start is re-pulsed mid-run, 0 = never
        int         exp_err;
        logic       exp_pass;
    } run_t;

    run_t tbl[4];

    // One complete run: start pulse, then stim, done timing and results.
    task automatic do_run(input run_t r);
        int cyc;
        int stim_bad;
        logic busy_seen;
        mode = r.mode;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        stim_bad = 0;
        busy_seen = busy;
        while (done !== 1'b1 && cyc < 200) begin
            if (cyc >= 2 && (cyc - 2) % 4 == 0 && (cyc - 2) / 4 < 16) begin
                if (stim !== pat[(cyc - 2) / 4]) stim_bad++;
            end
            start = (cyc == r.start_at);
            tick();
            cyc++;
        end
        start = 1'b0;
        check({r.name, "_busy_run"}, busy_seen, 1);
        check({r.name, "_done_cycle"}, cyc, 65);
        check({r.name, "_stim_seq_errs"}, stim_bad, 0);
        check({r.name, "_err_count"}, err_count, r.exp_err);
        check({r.name, "_vec_idx_last"}, vec_idx, 15);
        tick();
        check({r.name, "_done_pulse_end"}, done, 0);
        check({r.name, "_busy_idle"}, busy, 0);
        check({r.name, "_pass"}, pass, r.exp_pass);
        check({r.name, "_err_hold"}, err_count, r.exp_err);
    endtask

    initial begin
        int cyc;
        int done_hits;
        logic [15:0] tmp;

`ifdef INV_CHK_LFSR_EN
        tmp = 16'h8F59;
        zeros16 = 7;
`else
        tmp = 16'hAAAA;
        zeros16 = 8;
`endif
        pat = tmp;

        tbl[0] = '{"ideal",      2'd0, 0,  0,       1'b1};
        tbl[1] = '{"stuck0",     2'd1, 0,  zeros16, 1'b0};
        tbl[2] = '{"buffer",     2'd2, 0,  16,      1'b0};
        tbl[3] = '{"start_busy", 2'd0, 14, 0,       1'b1};

        mode = 2'd0;
        start = 1'b0;
        start_b = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_stim", stim, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_vec", vec_idx, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) begin
            do_run(tbl[i]);
            tick();
        end

        // Reset asserted in vector 5 SETTLE clears everything at once.
        mode = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 22) begin
            tick();
            cyc++;
        end
        check("mid_vec_before", vec_idx, 5);
        check("mid_err_before", err_count, 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stim", stim, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err_count, 0);
        check("mid_rst_vec", vec_idx, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_pass", pass, 0);
        tick();
        tick();
        rst_n = 1'b1;
        done_hits = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_hits++;
        end
        check("mid_rst_no_resume", done_hits, 0);
        do_run('{"post_reset", 2'd0, 0, 0, 1'b1});
        tick();

        // start held high across DONE launches a second run right away.
        mode = 2'd0;
        start = 1'b1;
        tick();
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("held_done1_cycle", cyc, 65);
        tick();
        cyc++;
        check("held_idle_busy", busy, 0);
        tick();
        cyc++;
        check("held_restart_busy", busy, 1);
        check("held_restart_vec", vec_idx, 0);
        start = 1'b0;
        while (done !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        check("held_done2_cycle", cyc, 131);
        tick();
        check("held_pass", pass, 1);

        // 255-vector run against a buffer saturates the error counter.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 1;
        while (done_b !== 1'b1 && cyc < 1200) begin
            tick();
            cyc++;
        end
        check("big_done_cycle", cyc, 1021);
        check("big_err_sat", err_b, 255);
        check("big_vec_last", vec_b, 254);
        tick();
        check("big_pass", pass_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
